// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall control logic.
package pipeline_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard and stall sequencer for the 5-stage pipeline: memory waits, deferred
// branch flushes and load-use interlocks, plus saturating stall counters.
module pipeline_stall_controller
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memToReg,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             bubble_at_ex,
    output logic             bubble_at_wb,
    output logic             flush_if_id,
    output logic             mem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

    state_e          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic            mem_timeout_q, mem_timeout_d;

    logic load_use, mem_stall, flush;
    logic lu_en, ms_en;
    logic stall_front_c, stall_back_c, bubble_ex_c, bubble_wb_c, flush_c, req_c;

    assign load_use = ex_memToReg && (ex_rd != ZERO_REG) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        flush_pend_d  = flush_pend_q;
        mem_timeout_d = mem_timeout_q;
        mem_stall     = 1'b0;
        flush         = 1'b0;
        lu_en         = 1'b0;
        ms_en         = 1'b0;
        stall_front_c = 1'b0;
        stall_back_c  = 1'b0;
        bubble_ex_c   = 1'b0;
        bubble_wb_c   = 1'b0;
        flush_c       = 1'b0;
        req_c         = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_access) begin
                    req_c = 1'b1;
                    if (!mem_ready) begin
                        mem_stall  = 1'b1;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WC_ONE;
                    end
                end
            end
            MEM_WAIT: begin
                req_c     = 1'b1;
                mem_stall = 1'b1;
                ms_en     = 1'b1;
                if (wait_cnt_q == WC_MAX) begin
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_ONE;
                end
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: state_d = RUN;
        endcase

        // A memory stall freezes everything; a branch seen now is replayed once it lifts.
        if (mem_stall) begin
            stall_front_c = 1'b1;
            stall_back_c  = 1'b1;
            bubble_wb_c   = 1'b1;
            if (branch_taken) begin
                flush_pend_d = 1'b1;
            end
        end else begin
            flush = branch_taken || flush_pend_q;
            if (flush) begin
                flush_c      = 1'b1;
                bubble_ex_c  = 1'b1;
                flush_pend_d = 1'b0;
            end else if (load_use) begin
                stall_front_c = 1'b1;
                bubble_ex_c   = 1'b1;
                lu_en         = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            flush_pend_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            flush_pend_q  <= flush_pend_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .en_i   (lu_en),
        .cnt_o  (load_use_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mem_stall_cnt (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .en_i   (ms_en),
        .cnt_o  (mem_stall_cnt)
    );

    // Decoded controls are forced low while reset is asserted, even with live inputs.
    assign stall_pc     = reset_n & stall_front_c;
    assign stall_if_id  = reset_n & stall_front_c;
    assign stall_id_ex  = reset_n & stall_back_c;
    assign stall_ex_mem = reset_n & stall_back_c;
    assign bubble_at_ex = reset_n & bubble_ex_c;
    assign bubble_at_wb = reset_n & bubble_wb_c;
    assign flush_if_id  = reset_n & flush_c;
    assign mem_req      = reset_n & req_c;
    assign mem_timeout  = reset_n & mem_timeout_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed and randomized bench for pipeline_stall_controller against a cycle-level reference model.
module tb_pipeline_stall_controller;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_memToReg, mem_access, mem_ready, branch_taken;
    logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic             bubble_at_ex, bubble_at_wb, flush_if_id, mem_req, mem_timeout;
    logic [CNT_W-1:0] load_use_cnt, mem_stall_cnt;

    pipeline_stall_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memToReg  (ex_memToReg),
        .ex_rd        (ex_rd),
        .mem_access   (mem_access),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .bubble_at_ex (bubble_at_ex),
        .bubble_at_wb (bubble_at_wb),
        .flush_if_id  (flush_if_id),
        .mem_req      (mem_req),
        .mem_timeout  (mem_timeout),
        .load_use_cnt (load_use_cnt),
        .mem_stall_cnt(mem_stall_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // Reference model: "waiting" means an access is outstanding; wait_len is the
    // 1-based index of the current waiting cycle, unbounded.
    bit m_waiting, m_pend, m_tmo;
    int m_wait_len, m_lu, m_ms;
    int flush_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_waiting  = 1'b0;
        m_pend     = 1'b0;
        m_tmo      = 1'b0;
        m_wait_len = 0;
        m_lu       = 0;
        m_ms       = 0;
    endtask

    task automatic set_in(input bit acc, input bit rdy, input bit br, input bit mtr,
                          input int rd, input int rs, input int rt, input bit urt);
        mem_access   = acc;
        mem_ready    = rdy;
        branch_taken = br;
        ex_memToReg  = mtr;
        ex_rd        = 5'(rd);
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_uses_rt   = urt;
    endtask

    function automatic logic [8:0] observed();
        return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_at_ex,
                bubble_at_wb, flush_if_id, mem_req, mem_timeout};
    endfunction

    // Called at a falling edge with inputs set; checks, then advances one clock.
    task automatic step();
        bit hazard, freeze, fl;
        logic [8:0] exp_v;
        #1;
        hazard = ex_memToReg && ex_rd != 0 &&
                 (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        freeze = m_waiting || (mem_access && !mem_ready);
        fl     = branch_taken || m_pend;
        if (freeze)
            exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, m_tmo};
        else
            exp_v = {hazard && !fl, hazard && !fl, 1'b0, 1'b0, fl || hazard,
                     1'b0, fl, mem_access, m_tmo};
        check("outputs", 32'(observed()), 32'(exp_v));
        check("load_use_cnt", 32'(load_use_cnt), 32'(m_lu));
        check("mem_stall_cnt", 32'(mem_stall_cnt), 32'(m_ms));
        if (flush_if_id) flush_seen++;
        @(posedge clock);
        if (m_waiting) begin
            if (m_ms < CMAX) m_ms++;
            if (m_wait_len >= TIMEOUT) m_tmo = 1'b1;
            if (mem_ready) m_waiting = 1'b0;
            else m_wait_len++;
        end else if (mem_access && !mem_ready) begin
            m_waiting  = 1'b1;
            m_wait_len = 1;
        end
        if (freeze) begin
            if (branch_taken) m_pend = 1'b1;
        end else begin
            m_pend = 1'b0;
            if (hazard && !fl && m_lu < CMAX) m_lu++;
        end
        @(negedge clock);
    endtask

    initial begin
        model_reset();
        flush_seen = 0;
        reset_n = 1'b0;
        set_in(1, 0, 1, 1, 3, 3, 0, 0);
        #3;
        check("reset_outputs", 32'(observed()), 32'd0);
        check("reset_lu_cnt", 32'(load_use_cnt), 32'd0);
        check("reset_ms_cnt", 32'(mem_stall_cnt), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Load-use: one-cycle interlock, then self-clears
        set_in(0, 0, 0, 1, 5, 5, 0, 0);
        step();
        check("lu_count_one", 32'(load_use_cnt), 32'd1);
        set_in(0, 0, 0, 0, 5, 5, 0, 0);
        step();

        // Load into $0 never interlocks
        set_in(0, 0, 0, 1, 0, 0, 0, 1);
        step();
        check("lu_zero_reg", 32'(load_use_cnt), 32'd1);

        // Use through rt only when the instruction reads rt
        set_in(0, 0, 0, 1, 9, 1, 9, 0);
        step();
        set_in(0, 0, 0, 1, 9, 1, 9, 1);
        step();

        // Memory wait: ready low 3 cycles then high
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        check("ms_count_three", 32'(mem_stall_cnt), 32'd3);
        step();

        // Branch during wait: flush deferred, fires once after return to RUN
        flush_seen = 0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_in(1, 0, 1, 0, 0, 0, 0, 0);
        step();
        set_in(1, 1, 1, 0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("deferred_flush_once", 32'(flush_seen), 32'd1);

        // Branch beats load-use
        set_in(0, 0, 1, 1, 7, 7, 0, 0);
        step();
        check("branch_over_lu", 32'(load_use_cnt), 32'd2);

        // Watchdog: ready never arrives
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (7) step();
        check("timeout_sticky", 32'(mem_timeout), 32'd1);

        // Asynchronous reset in the middle of a wait
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(observed()), 32'd0);
        check("async_reset_ms_cnt", 32'(mem_stall_cnt), 32'd0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        step();

        // Counter saturation
        for (int i = 0; i < CMAX + 3; i++) begin
            set_in(0, 0, 0, 1, 1 + (i % 31), 1 + (i % 31), 0, 0);
            step();
        end
        check("lu_saturated", 32'(load_use_cnt), 32'(CMAX));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
                   $urandom % 2, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 2);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central hazard/stall sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Generates per-stage hold and bubble controls consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers; bubble_at_wb is the signal mem_wb reads.
- Handles load-use hazards, variable-latency data-memory accesses (req/ready handshake with watchdog) and taken-branch flushes deferred across memory stalls.
- Keeps saturating stall-cycle counters.

Parameters:
- TIMEOUT, 64, cycles MEM_WAIT may last before mem_timeout fires.
- CNT_W, 32, width of each performance counter.

Ports:
- clock  in  1  pipeline clock, all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs of instruction in ID.
- id_rt  in  5  rt of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memToReg  in  1  EX instruction is a load.
- ex_rd  in  5  destination of EX instruction.
- mem_access  in  1  instruction in MEM performs a load or store.
- mem_ready  in  1  data memory completes the current access.
- branch_taken  in  1  EX resolved a taken branch/jump.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold if_id.
- stall_id_ex  out  1  hold id_ex.
- stall_ex_mem  out  1  hold ex_mem.
- bubble_at_ex  out  1  load zeros into id_ex.
- bubble_at_wb  out  1  load zeros into mem_wb.
- flush_if_id  out  1  load zeros into if_id.
- mem_req  out  1  data memory request strobe.
- mem_timeout  out  1  sticky watchdog error.
- load_use_cnt  out  CNT_W  load-use stall cycles.
- mem_stall_cnt  out  CNT_W  memory-wait cycles.

Behaviour:
- Reset (async, reset_n=0):
  - state=RUN, flush_pend=0, wait_cnt=0, both counters=0, mem_timeout=0.
  - All outputs 0 while reset_n=0.
- States: RUN, MEM_WAIT.
- load_use (combinational): ex_memToReg && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
- RUN, mem_access=1:
  - mem_req=1 the same cycle.
  - If mem_ready=1 the same cycle (zero-wait), no stall and remain in RUN.
  - Else assert stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and bubble_at_wb this cycle; next state MEM_WAIT; wait_cnt<=1.
- MEM_WAIT:
  - mem_req=1; all four stalls and bubble_at_wb held at 1.
  - mem_stall_cnt increments each cycle.
  - wait_cnt increments each cycle, saturating at TIMEOUT.
  - mem_ready=1: stalls and bubble still asserted that cycle; next state RUN, wait_cnt<=0.
  - wait_cnt==TIMEOUT: mem_timeout<=1 (sticky until reset); remain in MEM_WAIT.
- Load-use, RUN with no memory stall that cycle:
  - stall_pc=1, stall_if_id=1, bubble_at_ex=1 for exactly that cycle.
  - load_use_cnt increments.
  - Next cycle the load has left EX, so the hazard self-clears; no extra state is needed.
- Branch, RUN with no memory stall:
  - branch_taken=1 gives flush_if_id=1 and bubble_at_ex=1 the same cycle.
  - Flush overrides the load-use stall: stall_pc=0 and stall_if_id=0, so the PC takes the branch target. load_use_cnt does not increment.
- Branch arriving while a memory stall is active (entering or in MEM_WAIT):
  - flush_pend<=1; the flush is not applied during the stall.
  - On the first RUN cycle after MEM_WAIT, flush_if_id=1 and bubble_at_ex=1 from flush_pend, then flush_pend<=0.
  - branch_taken is held by the frozen id_ex/ex_mem registers, so the pending flush fires exactly once; flush_pend is cleared when it is used.
- Priority: memory stall > branch flush > load-use.
- Counters saturate at all-ones and never wrap.
- Reset mid-MEM_WAIT returns to RUN immediately and drops mem_req; the outstanding access is abandoned.

Decomposition:
- Shared package pipeline_pkg holds the state enum (RUN, MEM_WAIT), REG_W=5, and the zero-register constant 5'd0.
- One sub-module, sat_counter (CNT_W, enable, async active-low reset), instanced twice for the performance counters.
- Hazard compare and output decode stay inline.

Test Plan:
- Load-use: ex_memToReg=1, ex_rd=5, id_rs=5 -> one cycle of stall_pc=stall_if_id=bubble_at_ex=1; load_use_cnt=1; next cycle all 0.
- Load to $0: ex_rd=0 matching id_rs=0 -> no stall; load_use_cnt=0.
- Memory wait: mem_access=1, mem_ready low for 3 cycles then high -> stalls and bubble_at_wb high for 4 cycles; mem_stall_cnt=3; state returns to RUN.
- Branch during wait: branch_taken=1 while in MEM_WAIT, ready after 2 cycles -> no flush during the stall; flush_if_id=1 on exactly one cycle after return to RUN.
- Branch vs load-use: branch_taken=1 and load_use=1 in the same cycle -> flush_if_id=1, bubble_at_ex=1, stall_pc=0, load_use_cnt unchanged.
- Watchdog/reset: mem_ready held low with TIMEOUT=4 -> mem_timeout=1 from the 5th MEM_WAIT cycle; reset_n pulled low asynchronously -> all outputs 0 immediately, state RUN.
